mem_access_unit: RTL and testbench

- Memory-stage load/store engine for the MIPS pipeline.
- Consumes the EX-stage ALU result as the effective address and the rt value as store data.
- Drives an SRAM-like data bus with a req/addr_ok/data_ok handshake and returns aligned, sign- or zero-extended load data to writeback.
- Raises AdEL/AdES on misalignment and stalls the pipeline while a bus transaction is outstanding.

---
 rtl/mem_defs_pkg.sv | 45 ++++
 rtl/mem_lane_align.sv | 64 ++++++
 rtl/mem_access_unit.sv | 138 +++++++++++++
 tb/tb_mem_access_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_defs_pkg.sv
// Shared definitions for the memory-stage load/store engine.
// Latency: n/a (constants, types and pure helper functions only).
// Backpressure: n/a.
// Contents: op codes, bus size codes, FSM state encoding, op classification helpers.
package mem_defs;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } mem_state_t;

  // Stores occupy the top three op codes.
  function automatic logic op_is_store(input logic [2:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Natural alignment: halves need bit 0 clear, words need bits 1:0 clear.
  function automatic logic op_aligned(input logic [2:0] op, input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b1;
    case (op)
      OP_LH, OP_LHU, OP_SH: ok = ~addr_lo[0];
      OP_LW, OP_SW:         ok = (addr_lo == 2'b00);
      default:              ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane formatting: store strobes/replicated data/size, load extraction and extension.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
// Ports: op, addr_lo (address bits 1:0), wdata (store data), rdata (bus read data)
//        -> size, wstrb, bus_wdata, load_data.
module mem_lane_align
  import mem_defs::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [1:0]  size,
  output logic [3:0]  wstrb,
  output logic [31:0] bus_wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    // Move the addressed byte/half down to bit 0 before extension.
    shifted   = rdata >> {addr_lo, 3'b000};
    size      = SZ_WORD;
    wstrb     = 4'b0000;
    bus_wdata = wdata;
    load_data = shifted;
    case (op)
      OP_LB: begin
        size      = SZ_BYTE;
        load_data = {{24{shifted[7]}}, shifted[7:0]};
      end
      OP_LBU: begin
        size      = SZ_BYTE;
        load_data = {24'b0, shifted[7:0]};
      end
      OP_LH: begin
        size      = SZ_HALF;
        load_data = {{16{shifted[15]}}, shifted[15:0]};
      end
      OP_LHU: begin
        size      = SZ_HALF;
        load_data = {16'b0, shifted[15:0]};
      end
      OP_SB: begin
        size      = SZ_BYTE;
        wstrb     = 4'b0001 << addr_lo;
        bus_wdata = {4{wdata[7:0]}};
      end
      OP_SH: begin
        size      = SZ_HALF;
        wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
        bus_wdata = {2{wdata[15:0]}};
      end
      OP_SW: begin
        wstrb = 4'b1111;
      end
      default: begin
        size = SZ_WORD;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MIPS M-stage load/store engine driving an SRAM-like req/addr_ok/data_ok bus.
// Latency: accept, addr_ok, data_ok, then result in DONE (3 stall cycles best case).
// Backpressure: mem_stall holds the pipeline while a transaction is outstanding;
//   request fields are held stable until addr_ok; DONE waits for pipe_adv.
// Ports: clk/rst; mem_valid/mem_op/mem_addr/mem_wdata from EX; flush, pipe_adv from
//   pipeline control; data_sram_* bus; load_result, mem_stall, adel/ades/badvaddr out.
module mem_access_unit
  import mem_defs::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic [2:0]        mem_op,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic              flush,
  input  logic              pipe_adv,
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [1:0]        data_sram_size,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [3:0]        data_sram_wstrb,
  output logic [31:0]       data_sram_wdata,
  input  logic              data_sram_addr_ok,
  input  logic              data_sram_data_ok,
  input  logic [31:0]       data_sram_rdata,
  output logic [31:0]       load_result,
  output logic              mem_stall,
  output logic              adel,
  output logic              ades,
  output logic [ADDR_W-1:0] badvaddr
);

  mem_state_t        state, state_nxt;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic        in_store, in_aligned, misaligned, accept, capture;
  logic [1:0]  size_a;
  logic [3:0]  wstrb_a;
  logic [31:0] wdata_a, load_a;

  assign in_store   = op_is_store(mem_op);
  assign in_aligned = op_aligned(mem_op, mem_addr[1:0]);
  assign misaligned = mem_valid & ~in_aligned;
  assign adel       = misaligned & ~in_store;
  assign ades       = misaligned & in_store;
  assign badvaddr   = misaligned ? mem_addr : '0;
  assign accept     = (state == ST_IDLE) & mem_valid & in_aligned & ~flush;

  mem_lane_align u_align (
    .op        (op_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (data_sram_rdata),
    .size      (size_a),
    .wstrb     (wstrb_a),
    .bus_wdata (wdata_a),
    .load_data (load_a)
  );

  always_comb begin
    state_nxt = state;
    mem_stall = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_REQ;
          mem_stall = 1'b1;
        end
      end
      ST_REQ: begin
        mem_stall = 1'b1;
        // Once accepted the slave owes us data_ok, so a flush must drain it.
        if (data_sram_addr_ok)
          state_nxt = flush ? ST_DRAIN : ST_WAIT;
        else if (flush)
          state_nxt = ST_IDLE;
      end
      ST_WAIT: begin
        mem_stall = 1'b1;
        if (data_sram_data_ok) begin
          if (flush) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_DONE;
            capture   = 1'b1;
          end
        end else if (flush) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (pipe_adv || flush)
          state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        // Keep a new access from issuing while the orphaned response is pending.
        mem_stall = mem_valid;
        if (data_sram_data_ok)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      load_result <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q    <= mem_op;
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
      end
      if (capture && !op_is_store(op_q))
        load_result <= load_a;
    end
  end

  // Bus fields are only driven while requesting so the bus idles at zero.
  assign data_sram_req   = (state == ST_REQ);
  assign data_sram_wr    = data_sram_req & op_is_store(op_q);
  assign data_sram_size  = data_sram_req ? size_a  : 2'b00;
  assign data_sram_addr  = data_sram_req ? addr_q  : '0;
  assign data_sram_wstrb = data_sram_req ? wstrb_a : 4'b0000;
  assign data_sram_wdata = data_sram_req ? wdata_a : 32'b0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalignment, flush/drain, DONE hold, reset.
// Inputs change 1 time unit after posedge; outputs are sampled at negedge.
module tb_mem_access_unit;
  import mem_defs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [2:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        flush;
  logic        pipe_adv;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [31:0] load_result;
  logic        mem_stall;
  logic        adel;
  logic        ades;
  logic [31:0] badvaddr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .mem_valid         (mem_valid),
    .mem_op            (mem_op),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .flush             (flush),
    .pipe_adv          (pipe_adv),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .load_result       (load_result),
    .mem_stall         (mem_stall),
    .adel              (adel),
    .ades              (ades),
    .badvaddr          (badvaddr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; mem_valid = 1'b0; mem_op = 3'd0; mem_addr = 32'h0; mem_wdata = 32'h0;
    flush = 1'b0; pipe_adv = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h0;
    tick(); tick();
    rst = 1'b0;
    sample();
    chk("rst_req", {31'b0, data_sram_req}, 32'h0);
    chk("rst_stall", {31'b0, mem_stall}, 32'h0);
    chk("rst_load_result", load_result, 32'h0);
    chk("rst_wstrb", {28'b0, data_sram_wstrb}, 32'h0);
    chk("rst_addr", data_sram_addr, 32'h0);

    // LB at 0x1003, immediate acks.
    tick();
    mem_valid = 1'b1; mem_op = OP_LB; mem_addr = 32'h0000_1003;
    sample();
    chk("lb_c0_stall", {31'b0, mem_stall}, 32'h1);
    chk("lb_c0_req", {31'b0, data_sram_req}, 32'h0);
    chk("lb_c0_adel", {31'b0, adel}, 32'h0);
    chk("lb_c0_badvaddr", badvaddr, 32'h0);
    tick();
    data_sram_addr_ok = 1'b1;
    sample();
    chk("lb_c1_req", {31'b0, data_sram_req}, 32'h1);
    chk("lb_c1_addr", data_sram_addr, 32'h0000_1003);
    chk("lb_c1_size", {30'b0, data_sram_size}, 32'h0);
    chk("lb_c1_wr", {31'b0, data_sram_wr}, 32'h0);
    chk("lb_c1_wstrb", {28'b0, data_sram_wstrb}, 32'h0);
    chk("lb_c1_stall", {31'b0, mem_stall}, 32'h1);
    tick();
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_FF7F;
    sample();
    chk("lb_c2_req", {31'b0, data_sram_req}, 32'h0);
    chk("lb_c2_stall", {31'b0, mem_stall}, 32'h1);
    tick();
    data_sram_data_ok = 1'b0; pipe_adv = 1'b1;
    sample();
    chk("lb_c3_stall", {31'b0, mem_stall}, 32'h0);
    chk("lb_c3_result", load_result, 32'hFFFF_FF80);
    chk("lb_c3_req", {31'b0, data_sram_req}, 32'h0);
    tick();
    pipe_adv = 1'b0;

    // SH at 0x2002, addr_ok held off for three cycles.
    mem_op = OP_SH; mem_addr = 32'h0000_2002; mem_wdata = 32'h1234_ABCD;
    sample();
    chk("sh_c0_stall", {31'b0, mem_stall}, 32'h1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      data_sram_addr_ok = (i == 4);
      sample();
      chk($sformatf("sh_c%0d_req", i), {31'b0, data_sram_req}, 32'h1);
      chk($sformatf("sh_c%0d_addr", i), data_sram_addr, 32'h0000_2002);
      chk($sformatf("sh_c%0d_wstrb", i), {28'b0, data_sram_wstrb}, 32'hC);
      chk($sformatf("sh_c%0d_wdata", i), data_sram_wdata, 32'hABCD_ABCD);
      chk($sformatf("sh_c%0d_wr", i), {31'b0, data_sram_wr}, 32'h1);
      chk($sformatf("sh_c%0d_size", i), {30'b0, data_sram_size}, 32'h1);
    end
    tick();
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5555_5555;
    sample();
    chk("sh_wait_req", {31'b0, data_sram_req}, 32'h0);
    tick();
    data_sram_data_ok = 1'b0; pipe_adv = 1'b1;
    sample();
    chk("sh_done_stall", {31'b0, mem_stall}, 32'h0);
    chk("sh_load_result_kept", load_result, 32'hFFFF_FF80);
    tick();
    pipe_adv = 1'b0;

    // Misaligned LW and SW.
    mem_op = OP_LW; mem_addr = 32'h0000_0006;
    sample();
    chk("lw_mis_adel", {31'b0, adel}, 32'h1);
    chk("lw_mis_ades", {31'b0, ades}, 32'h0);
    chk("lw_mis_badvaddr", badvaddr, 32'h0000_0006);
    chk("lw_mis_stall", {31'b0, mem_stall}, 32'h0);
    tick();
    sample();
    chk("lw_mis_no_req", {31'b0, data_sram_req}, 32'h0);
    tick();
    mem_op = OP_SW; mem_addr = 32'h0000_0005;
    sample();
    chk("sw_mis_ades", {31'b0, ades}, 32'h1);
    chk("sw_mis_adel", {31'b0, adel}, 32'h0);
    chk("sw_mis_badvaddr", badvaddr, 32'h0000_0005);
    chk("sw_mis_stall", {31'b0, mem_stall}, 32'h0);
    tick();
    sample();
    chk("sw_mis_no_req", {31'b0, data_sram_req}, 32'h0);

    // LW flushed in WAIT, followed by a second LW that must wait out the drain.
    tick();
    mem_op = OP_LW; mem_addr = 32'h0000_0100;
    tick();
    data_sram_addr_ok = 1'b1;
    sample();
    chk("fl_req1_addr", data_sram_addr, 32'h0000_0100);
    tick();
    data_sram_addr_ok = 1'b0; flush = 1'b1;
    sample();
    chk("fl_wait_stall", {31'b0, mem_stall}, 32'h1);
    tick();
    flush = 1'b0; mem_addr = 32'h0000_0200;
    sample();
    chk("fl_drain1_req", {31'b0, data_sram_req}, 32'h0);
    chk("fl_drain1_stall", {31'b0, mem_stall}, 32'h1);
    tick();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
    sample();
    chk("fl_drain2_req", {31'b0, data_sram_req}, 32'h0);
    chk("fl_drain2_stall", {31'b0, mem_stall}, 32'h1);
    tick();
    data_sram_data_ok = 1'b0;
    sample();
    chk("fl_accept2_req", {31'b0, data_sram_req}, 32'h0);
    chk("fl_accept2_stall", {31'b0, mem_stall}, 32'h1);
    chk("fl_discarded", load_result, 32'hFFFF_FF80);
    tick();
    data_sram_addr_ok = 1'b1;
    sample();
    chk("fl_req2", {31'b0, data_sram_req}, 32'h1);
    chk("fl_req2_addr", data_sram_addr, 32'h0000_0200);
    tick();
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFE_F00D;
    tick();
    data_sram_data_ok = 1'b0;

    // DONE held by an external stall for four cycles.
    for (int i = 0; i < 4; i++) begin
      sample();
      chk($sformatf("hold%0d_result", i), load_result, 32'hCAFE_F00D);
      chk($sformatf("hold%0d_req", i), {31'b0, data_sram_req}, 32'h0);
      chk($sformatf("hold%0d_stall", i), {31'b0, mem_stall}, 32'h0);
      tick();
    end
    pipe_adv = 1'b1;
    tick();
    pipe_adv = 1'b0; mem_valid = 1'b0;
    sample();
    chk("hold_exit_stall", {31'b0, mem_stall}, 32'h0);
    chk("hold_exit_req", {31'b0, data_sram_req}, 32'h0);

    // LHU at 0x3002.
    tick();
    mem_valid = 1'b1; mem_op = OP_LHU; mem_addr = 32'h0000_3002;
    tick();
    data_sram_addr_ok = 1'b1;
    sample();
    chk("lhu_size", {30'b0, data_sram_size}, 32'h1);
    tick();
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8001_0000;
    tick();
    data_sram_data_ok = 1'b0; pipe_adv = 1'b1;
    sample();
    chk("lhu_result", load_result, 32'h0000_8001);
    tick();
    pipe_adv = 1'b0;

    // Reset while requesting.
    mem_op = OP_LW; mem_addr = 32'h0000_0400;
    tick();
    rst = 1'b1;
    sample();
    chk("rstreq_req_before", {31'b0, data_sram_req}, 32'h1);
    tick();
    rst = 1'b0; mem_valid = 1'b0;
    sample();
    chk("rstreq_req_after", {31'b0, data_sram_req}, 32'h0);
    chk("rstreq_stall_after", {31'b0, mem_stall}, 32'h0);
    chk("rstreq_load_result", load_result, 32'h0);
    tick();
    mem_valid = 1'b1;
    sample();
    chk("rstreq_idle_accept", {31'b0, mem_stall}, 32'h1);
    tick();
    mem_valid = 1'b0;
    sample();
    chk("rstreq_new_req", {31'b0, data_sram_req}, 32'h1);
    chk("rstreq_new_addr", data_sram_addr, 32'h0000_0400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
